mem_wb_backend: RTL and testbench
=================================

Name: mem_wb_backend

Overview:
- Back half of the 5-stage MIPS pipeline. It consumes the EX-stage outputs: ALU result, store data, destination register and the MemRead/MemWrite/MemToReg/RegWrite control bits.
- Contains the EX/MEM register, the word-addressed data memory, a load-latency stall FSM and the MEM/WB register.
- Drives the register-file write port: write register, write data and write enable. This is the writer end of the register-file read path used in decode.

Parameters:
- DEPTH, 1024, data memory size in 32-bit words (power of 2).
- RD_LATENCY, 1, data memory load latency in cycles; legal range 1..4.

Ports:
- Clk  input  1  pipeline clock, rising edge.
- Reset  input  1  asynchronous, active-high; clears all pipeline state.
- ex_valid  input  1  EX stage holds a real instruction (0 = bubble).
- ex_alu_result  input  32  ALU result; the memory byte address for loads and stores.
- ex_store_data  input  32  rt value, used as store data.
- ex_write_reg  input  5  destination register, already selected by RegDst.
- ex_MemRead  input  1  instruction is a load.
- ex_MemWrite  input  1  instruction is a store.
- ex_MemToReg  input  1  writeback data selected from memory (1) or ALU (0).
- ex_RegWrite  input  1  instruction writes the register file.
- stall  output  1  upstream must hold its pipeline registers and EX inputs this cycle.
- wb_write_reg  output  5  register-file write address.
- wb_write_data  output  32  register-file write data.
- wb_reg_write  output  1  register-file write enable.
- mem_error  output  1  sticky misaligned-access flag; only present with MISALIGN_TRAP_EN, tied 0 otherwise.

Behaviour:
- Reset:
  - EX/MEM and MEM/WB registers cleared (valid=0, data=0, reg=0).
  - FSM state = IDLE, counter = 0.
  - Outputs: stall=0, wb_reg_write=0, wb_write_reg=0, wb_write_data=0, mem_error=0.
  - Memory contents are not touched by reset; they are zero-initialised at time 0.
  - Reset mid-load aborts the load. No write reaches the register file.
- Memory addressing:
  - word index = exmem_alu_result[log2(DEPTH)+1:2].
  - Upper address bits are ignored, so addresses wrap modulo DEPTH words.
- EX/MEM register: captures the ex_* inputs on every rising edge while stall=0, and holds while stall=1.
- Store:
  - When exmem_valid & MemWrite, the memory word is written at the end of that cycle.
  - Single cycle; a store never stalls.
  - A load in the next cycle to the same address returns the new data.
- Load (exmem_valid & MemRead):
  - Memory is read combinationally; the RD_LATENCY delay is emulated by the FSM.
  - stall = exmem_valid & MemRead & (cnt != RD_LATENCY-1). With RD_LATENCY=1, stall is never asserted.
  - FSM states: IDLE and LOAD_WAIT.
  - IDLE → LOAD_WAIT when a load is in EX/MEM and RD_LATENCY>1; cnt increments.
  - LOAD_WAIT: cnt increments each cycle. When cnt == RD_LATENCY-1, stall drops, MEM/WB captures the load at the end of that cycle, and the FSM returns to IDLE with cnt=0.
  - Total stall cycles per load = RD_LATENCY-1.
  - Back-to-back loads each incur the full stall. No stall occurs between a load and a following non-load.
- MEM/WB register:
  - On every edge it captures the EX/MEM contents, or a bubble (valid=0) while stall=1.
  - The memory read data is captured alongside the ALU result.
- Writeback outputs (registered timing; combinational from MEM/WB):
  - wb_write_data = MemToReg ? load data : ALU result.
  - wb_reg_write = memwb_valid & RegWrite & (write_reg != 0). Writes to $0 are always suppressed.
- Latency: an instruction entering EX/MEM at edge N appears on the wb_* outputs after edge N+RD_LATENCY for loads, and after edge N+1 for all others.
- Illegal input: MemRead & MemWrite both set is treated as a store (no stall). The load data is discarded.

Optional Feature:
- MISALIGN_TRAP_EN defined:
  - If exmem_valid & (MemRead|MemWrite) & (alu_result[1:0] != 0), the access is misaligned.
  - A misaligned store is suppressed; a misaligned load suppresses its writeback (wb_reg_write=0) and does not stall.
  - mem_error is set on the next edge and stays 1 until Reset.
- MISALIGN_TRAP_EN undefined: the low 2 address bits are ignored and mem_error is constant 0.

Decomposition:
- Shared package/header holds:
  - the opcode-independent control bundle widths;
  - REG_ADDR_W=5 and DATA_W=32;
  - FSM state encodings IDLE=1'b0, LOAD_WAIT=1'b1.
- One sub-module, data_memory (DEPTH, synchronous write, combinational read), instantiated once. The FSM and pipeline registers stay in mem_wb_backend.

Test Plan:
- Reset release then ALU op (ex_alu_result=0x1234, RegWrite=1, MemToReg=0, write_reg=8) → one cycle later wb_reg_write=1, wb_write_reg=8, wb_write_data=0x1234; stall never high.
- Store 0xDEADBEEF to address 0x40, then load from 0x40 into $9, RD_LATENCY=1 → wb_write_data=0xDEADBEEF, no stall cycles.
- RD_LATENCY=3, load from 0x40 into $10 → stall high for exactly 2 cycles, EX inputs held; wb delivers 0xDEADBEEF 3 edges after entry, with bubbles (wb_reg_write=0) in between.
- ALU op with RegWrite=1, write_reg=0, result 0xFFFF → wb_reg_write stays 0.
- Assert Reset during the second stall cycle of a RD_LATENCY=3 load → stall=0 and wb_reg_write=0 immediately; FSM returns to IDLE; memory still holds 0xDEADBEEF.
- With MISALIGN_TRAP_EN: store to 0x42 → memory unchanged, mem_error=1 from the next edge and sticky until Reset. Without it: the word at 0x40 is written and mem_error=0.

Source files
------------

// File: rtl/mem_wb_backend_pkg.sv
// Shared widths, control bundle and load-FSM encoding for the MEM/WB back end.
// Used by mem_wb_backend and data_memory; optional MISALIGN_TRAP_EN lives in the top.
package mem_wb_backend_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int CTRL_W     = 4;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic reg_write;
    } ctrl_t;

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } ld_state_e;

endpackage

// File: rtl/mem_wb_backend_data_memory.sv
// Word-addressed data memory: synchronous write, combinational read on one shared address.
// Contents start at zero and are never touched by reset.
module data_memory
    import mem_wb_backend_pkg::*;
#(
    parameter int DEPTH = 1024,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH] = '{default: '0};

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_wb_backend.sv
// MIPS back end: EX/MEM register, data memory, load-latency stall FSM and MEM/WB register.
// Define MISALIGN_TRAP_EN to suppress misaligned accesses and raise the sticky mem_error flag.
//
// state     | meaning
// IDLE      | no multi-cycle load in progress (cnt = 0)
// LOAD_WAIT | load held in EX/MEM, counting toward RD_LATENCY-1
module mem_wb_backend
    import mem_wb_backend_pkg::*;
#(
    parameter int DEPTH      = 1024,
    parameter int RD_LATENCY = 1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  ex_valid,
    input  logic [DATA_W-1:0]     ex_alu_result,
    input  logic [DATA_W-1:0]     ex_store_data,
    input  logic [REG_ADDR_W-1:0] ex_write_reg,
    input  logic                  ex_MemRead,
    input  logic                  ex_MemWrite,
    input  logic                  ex_MemToReg,
    input  logic                  ex_RegWrite,
    output logic                  stall,
    output logic [REG_ADDR_W-1:0] wb_write_reg,
    output logic [DATA_W-1:0]     wb_write_data,
    output logic                  wb_reg_write,
    output logic                  mem_error
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] LAST_CNT = 2'(RD_LATENCY - 1);

    logic                  r_exmem_valid;
    logic [DATA_W-1:0]     r_exmem_alu;
    logic [DATA_W-1:0]     r_exmem_sd;
    logic [REG_ADDR_W-1:0] r_exmem_reg;
    ctrl_t                 r_exmem_ctrl;

    logic                  r_memwb_valid;
    logic [DATA_W-1:0]     r_memwb_alu;
    logic [DATA_W-1:0]     r_memwb_rdata;
    logic [REG_ADDR_W-1:0] r_memwb_reg;
    logic                  r_memwb_m2r;
    logic                  r_memwb_rw;

    ld_state_e             r_state;
    ld_state_e             w_state_nxt;
    logic [1:0]            r_cnt;
    logic [1:0]            w_cnt_nxt;

    logic                  w_misaligned;
    logic                  w_is_load;
    logic                  w_is_store;
    logic                  w_stall;
    logic [DATA_W-1:0]     w_rdata;

`ifdef MISALIGN_TRAP_EN
    assign w_misaligned = r_exmem_valid
                        & (r_exmem_ctrl.mem_read | r_exmem_ctrl.mem_write)
                        & (r_exmem_alu[1:0] != 2'b00);
`else
    assign w_misaligned = 1'b0;
`endif

    // MemRead together with MemWrite behaves as a plain store.
    assign w_is_store = r_exmem_valid & r_exmem_ctrl.mem_write & ~w_misaligned;
    assign w_is_load  = r_exmem_valid & r_exmem_ctrl.mem_read & ~r_exmem_ctrl.mem_write
                      & ~w_misaligned;
    assign w_stall    = w_is_load & (r_cnt != LAST_CNT);
    assign stall      = w_stall;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_exmem_valid <= 1'b0;
            r_exmem_alu   <= '0;
            r_exmem_sd    <= '0;
            r_exmem_reg   <= '0;
            r_exmem_ctrl  <= '0;
        end else if (!w_stall) begin
            r_exmem_valid <= ex_valid;
            r_exmem_alu   <= ex_alu_result;
            r_exmem_sd    <= ex_store_data;
            r_exmem_reg   <= ex_write_reg;
            r_exmem_ctrl  <= '{mem_read:   ex_MemRead,
                               mem_write:  ex_MemWrite,
                               mem_to_reg: ex_MemToReg,
                               reg_write:  ex_RegWrite};
        end
    end

    data_memory #(.DEPTH(DEPTH)) u_dmem (
        .i_clk   (Clk),
        .i_we    (w_is_store),
        .i_addr  (r_exmem_alu[AW+1:2]),
        .i_wdata (r_exmem_sd),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_is_load && (RD_LATENCY > 1)) begin
                    w_state_nxt = LOAD_WAIT;
                    w_cnt_nxt   = r_cnt + 2'd1;
                end
            end
            LOAD_WAIT: begin
                if (r_cnt == LAST_CNT) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + 2'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // A stalled load leaves a bubble behind; stores never forward memory data.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_memwb_valid <= 1'b0;
            r_memwb_alu   <= '0;
            r_memwb_rdata <= '0;
            r_memwb_reg   <= '0;
            r_memwb_m2r   <= 1'b0;
            r_memwb_rw    <= 1'b0;
        end else begin
            r_memwb_valid <= r_exmem_valid & ~w_stall;
            r_memwb_alu   <= r_exmem_alu;
            r_memwb_rdata <= w_rdata;
            r_memwb_reg   <= r_exmem_reg;
            r_memwb_m2r   <= r_exmem_ctrl.mem_to_reg & ~r_exmem_ctrl.mem_write;
            r_memwb_rw    <= r_exmem_ctrl.reg_write & ~(w_misaligned & r_exmem_ctrl.mem_read);
        end
    end

    assign wb_write_reg  = r_memwb_reg;
    assign wb_write_data = r_memwb_m2r ? r_memwb_rdata : r_memwb_alu;
    assign wb_reg_write  = r_memwb_valid & r_memwb_rw & (r_memwb_reg != '0);

`ifdef MISALIGN_TRAP_EN
    logic r_mem_error;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_mem_error <= 1'b0;
        end else if (w_misaligned) begin
            r_mem_error <= 1'b1;
        end
    end

    assign mem_error = r_mem_error;
`else
    assign mem_error = 1'b0;
`endif

endmodule

// File: tb/tb_mem_wb_backend.sv
// Bench for mem_wb_backend: directed steps on a RD_LATENCY=1 and a RD_LATENCY=3 instance,
// then random traffic on the latter against a transaction-level model (honours MISALIGN_TRAP_EN).
module tb_mem_wb_backend;

    localparam int D3   = 64;
    localparam int LAT3 = 3;

    typedef struct packed {
        logic        v;
        logic [31:0] alu;
        logic [31:0] sd;
        logic [4:0]  wr;
        logic        mr;
        logic        mw;
        logic        m2r;
        logic        rw;
    } ins_t;

    typedef struct {
        int unsigned cyc;
        logic [4:0]  rg;
        logic [31:0] data;
    } wb_t;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    logic        a_valid, a_mr, a_mw, a_m2r, a_rw;
    logic [31:0] a_alu, a_sd;
    logic [4:0]  a_wr;
    logic        a_stall, a_wb_reg_write, a_mem_error;
    logic [4:0]  a_wb_write_reg;
    logic [31:0] a_wb_write_data;

    logic        b_valid, b_mr, b_mw, b_m2r, b_rw;
    logic [31:0] b_alu, b_sd;
    logic [4:0]  b_wr;
    logic        b_stall, b_wb_reg_write, b_mem_error;
    logic [4:0]  b_wb_write_reg;
    logic [31:0] b_wb_write_data;

    mem_wb_backend #(.DEPTH(1024), .RD_LATENCY(1)) dut1 (
        .Clk(Clk), .Reset(Reset), .ex_valid(a_valid), .ex_alu_result(a_alu),
        .ex_store_data(a_sd), .ex_write_reg(a_wr), .ex_MemRead(a_mr), .ex_MemWrite(a_mw),
        .ex_MemToReg(a_m2r), .ex_RegWrite(a_rw), .stall(a_stall),
        .wb_write_reg(a_wb_write_reg), .wb_write_data(a_wb_write_data),
        .wb_reg_write(a_wb_reg_write), .mem_error(a_mem_error)
    );

    mem_wb_backend #(.DEPTH(D3), .RD_LATENCY(LAT3)) dut3 (
        .Clk(Clk), .Reset(Reset), .ex_valid(b_valid), .ex_alu_result(b_alu),
        .ex_store_data(b_sd), .ex_write_reg(b_wr), .ex_MemRead(b_mr), .ex_MemWrite(b_mw),
        .ex_MemToReg(b_m2r), .ex_RegWrite(b_rw), .stall(b_stall),
        .wb_write_reg(b_wb_write_reg), .wb_write_data(b_wb_write_data),
        .wb_reg_write(b_wb_reg_write), .mem_error(b_mem_error)
    );

    int unsigned total = 0;
    int unsigned passed = 0;

    bit [31:0]   mem_m [D3];
    wb_t         exp_q [$];
    int unsigned cyc3 = 0;
    int unsigned err_cyc = 0;
    int unsigned last_entry = 0;
    int unsigned stall_seen3 = 0;
    int unsigned exp_stall3 = 0;
    bit          pending3 = 0;
    bit          prev_stall3 = 0;
    ins_t        cur3;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic ins_t mk(input logic v, input logic [31:0] alu, input logic [31:0] sd,
                                input logic [4:0] wr, input logic mr, input logic mw,
                                input logic m2r, input logic rw);
        ins_t t;
        t.v = v; t.alu = alu; t.sd = sd; t.wr = wr;
        t.mr = mr; t.mw = mw; t.m2r = m2r; t.rw = rw;
        return t;
    endfunction

    task automatic drive1(input ins_t t);
        a_valid = t.v; a_alu = t.alu; a_sd = t.sd; a_wr = t.wr;
        a_mr = t.mr; a_mw = t.mw; a_m2r = t.m2r; a_rw = t.rw;
    endtask

    task automatic drive3(input ins_t t);
        b_valid = t.v; b_alu = t.alu; b_sd = t.sd; b_wr = t.wr;
        b_mr = t.mr; b_mw = t.mw; b_m2r = t.m2r; b_rw = t.rw;
    endtask

    // Instruction-level reference: sequential memory semantics plus a fixed latency per class.
    task automatic model_accept(input ins_t t, input int unsigned c);
        int unsigned idx;
        bit          mis;
        bit          is_load;
        bit [31:0]   rd;
        bit [31:0]   data;
        last_entry = c;
        if (t.v) begin
            idx = (t.alu / 4) % D3;
            mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
            mis = (t.mr || t.mw) && (t.alu % 4 != 0);
`endif
            if (mis && err_cyc == 0) err_cyc = c + 1;
            is_load = t.mr && !t.mw && !mis;
            rd = mem_m[idx];
            if (t.mw && !mis) mem_m[idx] = t.sd;
            data = (t.m2r && !t.mw) ? rd : t.alu;
            if (t.rw && t.wr != 0 && !(mis && t.mr))
                exp_q.push_back('{cyc: c + (is_load ? LAT3 : 1), rg: t.wr, data: data});
            if (is_load) exp_stall3 += LAT3 - 1;
        end
    endtask

    task automatic tick3();
        wb_t e;
        @(posedge Clk);
        #1;
        cyc3++;
        if (pending3 && !prev_stall3) begin
            model_accept(cur3, cyc3);
            pending3 = 0;
        end
        if (b_stall) stall_seen3++;
        if (b_wb_reg_write) begin
            if (exp_q.size() == 0) begin
                check("wb_unexpected", b_wb_reg_write, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("wb_cycle", cyc3, e.cyc);
                check("wb_reg", b_wb_write_reg, e.rg);
                check("wb_data", b_wb_write_data, e.data);
            end
        end else if (exp_q.size() != 0 && exp_q[0].cyc == cyc3) begin
            check("wb_missing", b_wb_reg_write, 1'b1);
            void'(exp_q.pop_front());
        end
        check("mem_error", b_mem_error, (err_cyc != 0 && cyc3 >= err_cyc));
        prev_stall3 = b_stall;
    endtask

    task automatic issue3(input ins_t t);
        cur3 = t;
        drive3(t);
        pending3 = 1;
        for (int i = 0; i < 10 && pending3; i++) tick3();
        if (pending3) begin
            check("issue_timeout", pending3, 1'b0);
            pending3 = 0;
        end
        drive3(mk(0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic reset_pulse();
        #2;
        Reset = 1'b1;
        exp_q.delete();
        pending3 = 0;
        prev_stall3 = 0;
        err_cyc = 0;
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    initial begin
        ins_t        bub;
        int unsigned le;
        int unsigned s0;
        int unsigned kind;
        int unsigned idx;
        logic [31:0] addr;

        bub = mk(0, 0, 0, 0, 0, 0, 0, 0);
        drive1(bub);
        drive3(bub);

        repeat (2) @(posedge Clk);
        #1;
        check("rst_stall1", a_stall, 1'b0);
        check("rst_wbwe1", a_wb_reg_write, 1'b0);
        check("rst_wbreg1", a_wb_write_reg, 5'd0);
        check("rst_wbdata1", a_wb_write_data, 32'd0);
        check("rst_err1", a_mem_error, 1'b0);
        check("rst_stall3", b_stall, 1'b0);
        check("rst_wbwe3", b_wb_reg_write, 1'b0);
        check("rst_wbdata3", b_wb_write_data, 32'd0);
        @(negedge Clk);
        Reset = 1'b0;

        // RD_LATENCY=1 instance: ALU op, store/load, write to $0
        drive1(mk(1, 32'h1234, 0, 5'd8, 0, 0, 0, 1));
        @(posedge Clk); #1;
        check("alu_nostall", a_stall, 1'b0);
        drive1(bub);
        @(posedge Clk); #1;
        check("alu_we", a_wb_reg_write, 1'b1);
        check("alu_reg", a_wb_write_reg, 5'd8);
        check("alu_data", a_wb_write_data, 32'h1234);

        drive1(mk(1, 32'h40, 32'hDEAD_BEEF, 0, 0, 1, 0, 0));
        @(posedge Clk); #1;
        check("st1_nostall", a_stall, 1'b0);
        drive1(mk(1, 32'h40, 0, 5'd9, 1, 0, 1, 1));
        @(posedge Clk); #1;
        check("ld1_nostall", a_stall, 1'b0);
        drive1(bub);
        @(posedge Clk); #1;
        check("ld1_we", a_wb_reg_write, 1'b1);
        check("ld1_reg", a_wb_write_reg, 5'd9);
        check("ld1_data", a_wb_write_data, 32'hDEAD_BEEF);

        drive1(mk(1, 32'hFFFF, 0, 5'd0, 0, 0, 0, 1));
        @(posedge Clk); #1;
        drive1(bub);
        @(posedge Clk); #1;
        check("r0_suppressed", a_wb_reg_write, 1'b0);

        // RD_LATENCY=3 instance: stall length, input hold, bubbles
        issue3(mk(1, 32'h40, 32'hDEAD_BEEF, 0, 0, 1, 0, 0));
        s0 = stall_seen3;
        issue3(mk(1, 32'h40, 0, 5'd10, 1, 0, 1, 1));
        le = last_entry;
        issue3(mk(1, 32'h55, 0, 5'd11, 0, 0, 0, 1));
        check("hold_entry", last_entry, le + LAT3);
        repeat (2) tick3();
        check("load_stall_cycles", stall_seen3 - s0, 2);

        // Reset during the second stall cycle
        issue3(mk(1, 32'h40, 0, 5'd11, 1, 0, 1, 1));
        tick3();
        check("midload_stalling", b_stall, 1'b1);
        #2;
        Reset = 1'b1;
        #1;
        check("rst_mid_stall", b_stall, 1'b0);
        check("rst_mid_we", b_wb_reg_write, 1'b0);
        reset_pulse();
        issue3(mk(1, 32'h40, 0, 5'd12, 1, 0, 1, 1));
        repeat (4) tick3();
        check("after_rst_drained", exp_q.size(), 0);

        // Misaligned store then readback of the aligned word
        issue3(mk(1, 32'h42, 32'h1234_5678, 0, 0, 1, 0, 0));
        repeat (2) tick3();
        issue3(mk(1, 32'h40, 0, 5'd13, 1, 0, 1, 1));
        repeat (4) tick3();
        check("err_sticky", b_mem_error, (err_cyc != 0));
        reset_pulse();
        #1;
        check("err_cleared", b_mem_error, 1'b0);

        // Random traffic; upper address bits exercise the modulo-DEPTH wrap
        stall_seen3 = 0;
        exp_stall3 = 0;
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 3);
            idx = $urandom_range(0, 7);
            addr = ($urandom() & 32'hFFFF_FF00) | (idx << 2);
            case (kind)
                0: issue3(bub);
                1: issue3(mk(1, $urandom(), 0, 5'($urandom_range(0, 31)), 0, 0, 0,
                             1'($urandom_range(0, 1))));
                2: issue3(mk(1, addr, 0, 5'($urandom_range(0, 31)), 1, 0, 1, 1));
                default: issue3(mk(1, addr, $urandom(), 0, 0, 1, 0, 0));
            endcase
            repeat ($urandom_range(0, 2)) tick3();
        end
        repeat (6) tick3();
        check("rand_drained", exp_q.size(), 0);
        check("rand_stall_total", stall_seen3, exp_stall3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
